// File: rtl/tdm_demux_1_8.sv
// 1:8 TDM lane demultiplexer: aligns on in_sync, reassembles frames, pulses out_valid.
// Optional frame counter output enabled by defining TDM_DEMUX_FRAME_CNT_EN.
module tdm_demux_1_8 #(
    parameter int LANES  = 8,
    parameter int DATA_W = 1,
    localparam int SEL_W = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_sync,
    output logic [SEL_W-1:0]        sel,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    out_valid,
`ifdef TDM_DEMUX_FRAME_CNT_EN
    output logic [15:0]             frame_cnt,
`endif
    output logic                    frame_err
);

    localparam int BUF_W = (LANES-1)*DATA_W;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES-1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                    state_q, state_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [BUF_W-1:0]          buf_q, buf_d;
    logic [LANES*DATA_W-1:0]   out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      frame_err_q, frame_err_d;

    logic at_zero, at_last;
    logic sync_ok, sync_early, lost, fill_last, fill_mid;

    assign at_zero    = (sel_q == '0);
    assign at_last    = (sel_q == LAST);
    assign sync_ok    = in_sync && at_zero;
    assign sync_early = in_sync && !at_zero;
    assign lost       = !in_sync && at_zero;
    assign fill_last  = !in_sync && at_last;
    assign fill_mid   = !in_sync && !at_zero && !at_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            buf_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            buf_q       <= buf_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        buf_d       = buf_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                IDLE: begin
                    // Unaligned: wait for a sync beat, drop everything else quietly
                    if (in_sync) begin
                        buf_d[0 +: DATA_W] = in_data;
                        sel_d              = SEL_W'(1);
                        state_d            = RUN;
                    end
                end
                RUN: begin
                    unique case (1'b1)
                        sync_ok: begin
                            buf_d[0 +: DATA_W] = in_data;
                            sel_d              = SEL_W'(1);
                        end
                        sync_early: begin
                            buf_d[0 +: DATA_W] = in_data;
                            sel_d              = SEL_W'(1);
                            frame_err_d        = 1'b1;
                        end
                        lost: begin
                            frame_err_d = 1'b1;
                            state_d     = IDLE;
                        end
                        fill_last: begin
                            out_data_d  = {in_data, buf_q};
                            out_valid_d = 1'b1;
                            sel_d       = '0;
                        end
                        fill_mid: begin
                            for (int k = 1; k < LANES-1; k++) begin
                                if (sel_q == SEL_W'(k))
                                    buf_d[k*DATA_W +: DATA_W] = in_data;
                            end
                            sel_d = sel_q + SEL_W'(1);
                        end
                        default: ;
                    endcase
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (out_valid_d)
            cnt_q <= cnt_q + 16'd1;
    end

    assign frame_cnt = cnt_q;
`endif

    assign sel       = sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_demux_1_8.sv
// Bench for tdm_demux_1_8: vector table, directed corner sequences, random vs queue model.
module tb_tdm_demux_1_8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [0:0] in_data = 1'b0;
    logic       in_sync = 1'b0;
    logic [2:0] sel;
    logic [7:0] out_data;
    logic       out_valid;
    logic       frame_err;
`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    tdm_demux_1_8 dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_sync  (in_sync),
        .sel      (sel),
        .out_data (out_data),
        .out_valid(out_valid),
`ifdef TDM_DEMUX_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int last_pulse = 0;
    int prev_pulse = 0;

    // Reference model: collected lanes of the current frame, alignment flag
    bit         aligned = 0;
    bit         frame_q[$];
    logic [7:0] exp_data = 8'h00;
    bit         exp_valid = 0;
    bit         exp_err = 0;
    int         exp_cnt = 0;

    typedef struct {
        bit         r, v, d, s;
        logic [7:0] od;
        bit         ov, fe;
        logic [2:0] sl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit v, bit d, bit s,
                                logic [7:0] od, bit ov, bit fe, int sl);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.s = s;
        t.od = od; t.ov = ov; t.fe = fe; t.sl = 3'(sl);
        return t;
    endfunction

    task automatic chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, act, exp);
        end
    endtask

    task automatic model(bit r, bit v, bit d, bit s);
        exp_valid = 0;
        exp_err   = 0;
        if (r) begin
            aligned = 0;
            frame_q.delete();
            exp_data = 8'h00;
            exp_cnt  = 0;
        end else if (v) begin
            if (!aligned) begin
                if (s) begin
                    frame_q.push_back(d);
                    aligned = 1;
                end
            end else if (s) begin
                exp_err = (frame_q.size() != 0);
                frame_q.delete();
                frame_q.push_back(d);
            end else if (frame_q.size() == 0) begin
                exp_err = 1;
                aligned = 0;
            end else begin
                frame_q.push_back(d);
                if (frame_q.size() == 8) begin
                    for (int k = 0; k < 8; k++) exp_data[k] = frame_q[k];
                    exp_valid = 1;
                    exp_cnt   = (exp_cnt + 1) % 65536;
                    frame_q.delete();
                end
            end
        end
    endtask

    task automatic step(bit r, bit v, bit d, bit s);
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; in_sync = s;
        @(posedge clk);
        cyc++;
        model(r, v, d, s);
        #1;
        if (out_valid) begin
            pulse_cnt++;
            prev_pulse = last_pulse;
            last_pulse = cyc;
        end
        chk("out_valid", int'(out_valid), int'(exp_valid));
        chk("frame_err", int'(frame_err), int'(exp_err));
        chk("out_data", int'(out_data), int'(exp_data));
        chk("sel", int'(sel), frame_q.size());
        chk("exclusive", int'(out_valid && frame_err), 0);
`ifdef TDM_DEMUX_FRAME_CNT_EN
        chk("frame_cnt", int'(frame_cnt), exp_cnt);
`endif
    endtask

    task automatic send_frame(logic [7:0] f, int gmin, int gmax);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) repeat ($urandom_range(gmax, gmin)) step(0, 0, 0, 0);
            step(0, 1, f[k], k == 0);
        end
    endtask

    initial begin
        int p0;
        vec_t t;
        logic [7:0] f;

        // Reset pair, then frame 0,1,0,1.. then early sync at lane 4
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 8'h00, 0, 0, 0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 1, k[0], k == 0, (k == 7) ? 8'hAA : 8'h00,
                             k == 7, 0, (k + 1) % 8));
        tbl.push_back(mk(0, 1, 1, 1, 8'hAA, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 8'hAA, 0, 0, 2));
        tbl.push_back(mk(0, 1, 1, 0, 8'hAA, 0, 0, 3));
        tbl.push_back(mk(0, 1, 1, 0, 8'hAA, 0, 0, 4));
        tbl.push_back(mk(0, 1, 1, 1, 8'hAA, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 8'hAA, 0, 0, 2));
        for (int k = 3; k < 8; k++)
            tbl.push_back(mk(0, 1, 0, 0, 8'hAA, 0, 0, k));
        tbl.push_back(mk(0, 1, 1, 0, 8'h83, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 8'h83, 0, 0, 0));

        foreach (tbl[i]) begin
            t = tbl[i];
            step(t.r, t.v, t.d, t.s);
            chk("tbl_data", int'(out_data), int'(t.od));
            chk("tbl_valid", int'(out_valid), int'(t.ov));
            chk("tbl_err", int'(frame_err), int'(t.fe));
            chk("tbl_sel", int'(sel), int'(t.sl));
        end

        // Gapped frame
        p0 = pulse_cnt;
        send_frame(8'hAA, 1, 3);
        repeat (3) step(0, 0, 0, 0);
        chk("gap_pulses", pulse_cnt - p0, 1);
        chk("gap_data", int'(out_data), 8'hAA);

        // Lost alignment at sel 0, non-sync beats ignored afterwards
        send_frame(8'hE8, 0, 0);
        chk("e8_data", int'(out_data), 8'hE8);
        step(0, 1, 1, 0);
        chk("lost_err", int'(frame_err), 1);
        p0 = pulse_cnt;
        for (int k = 0; k < 10; k++) step(0, 1, k[0], 0);
        chk("idle_pulses", pulse_cnt - p0, 0);
        chk("idle_data", int'(out_data), 8'hE8);
        chk("idle_sel", int'(sel), 0);

        // Back-to-back frames then reset mid-frame
        step(1, 0, 0, 0);
        send_frame(8'hAA, 0, 0);
        p0 = last_pulse;
        send_frame(8'h55, 0, 0);
        chk("b2b_spacing", last_pulse - prev_pulse, 8);
        chk("b2b_first", prev_pulse, p0);
        chk("b2b_data", int'(out_data), 8'h55);
`ifdef TDM_DEMUX_FRAME_CNT_EN
        chk("cnt_before_rst", int'(frame_cnt), 2);
`endif
        step(0, 1, 1, 1);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(1, 1, 1, 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_sel", int'(sel), 0);
`ifdef TDM_DEMUX_FRAME_CNT_EN
        chk("cnt_after_rst", int'(frame_cnt), 0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit r, v, d, s;
            r = ($urandom_range(199, 0) == 0);
            v = ($urandom_range(9, 0) < 7);
            d = 1'($urandom);
            if (frame_q.size() == 0)
                s = ($urandom_range(9, 0) < 8);
            else
                s = ($urandom_range(19, 0) == 0);
            step(r, v, d, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
